// File: rtl/wait_time_cnt.sv
// wait_time_cnt
//   Waiting-time counter for the taxi fare datapath. It counts minute pulses
//   from freq_div and shows the count as two BCD digits. The first FREE_MIN
//   minutes are free. After that, a one-cycle fee_pulse goes to the fare adder
//   every BILL_STEP billed minutes. The count saturates at MAX_MIN, and max
//   then tells freq_div to stop.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous reset, active low
//   en         waiting mode active (0 = pause; minute pulses are ignored)
//   clr        synchronous trip clear; beats every other synchronous event
//   min_pulse  minute pulse from freq_div; it may be wider than one cycle
//   wait_min   waiting minutes, packed BCD {tens, ones}
//   fee_pulse  one-cycle strobe, once per BILL_STEP billed minutes
//   max        high while wait_min has saturated at MAX_MIN
module wait_time_cnt #(
  parameter int FREE_MIN  = 3,   // 0 .. MAX_MIN-1
  parameter int BILL_STEP = 1,   // 1 .. 15
  parameter int MAX_MIN   = 99   // 1 .. 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic       min_pulse,
  output logic [7:0] wait_min,
  output logic       fee_pulse,
  output logic       max
);

  typedef enum logic [1:0] {IDLE, FREE, BILL, SAT} state_t;

  // Decimal limits re-expressed as packed BCD, so they compare directly
  // against the BCD counter.
  localparam logic [7:0] MAX_BCD  = 8'(((MAX_MIN / 10) << 4) | (MAX_MIN % 10));
  localparam logic [7:0] FREE_BCD = 8'(((FREE_MIN / 10) << 4) | (FREE_MIN % 10));
  localparam logic [3:0] STEP     = 4'(BILL_STEP);

  state_t     state;
  logic       pulse_d;
  logic [3:0] bill_cnt;
  logic       tick;
  logic [7:0] wait_inc;
  logic [3:0] bill_inc;

  // Rising edge of the minute pulse, qualified by en. A wide pulse gives
  // only one tick.
  assign tick     = min_pulse & ~pulse_d & en;
  assign bill_inc = bill_cnt + 4'd1;

  // BCD increment. Tens never passes 9 because the count saturates at or
  // below 99.
  // NOTE: give every always_comb output a value on every path (here a
  // default first); otherwise synthesis infers a latch.
  always_comb begin
    wait_inc = {wait_min[7:4], wait_min[3:0] + 4'd1};
    if (wait_min[3:0] == 4'd9) begin
      wait_inc = {wait_min[7:4] + 4'd1, 4'd0};
    end
  end

  // NOTE: registers take non-blocking assignments only. Every right-hand
  // side then reads the value from before the edge, whatever the statement
  // order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_min  <= 8'h00;
      fee_pulse <= 1'b0;
      max       <= 1'b0;
      pulse_d   <= 1'b0;
      bill_cnt  <= 4'd0;
    end else begin
      // The edge detector runs during pause and clear as well. A pulse that
      // is already high when en returns is therefore not counted again.
      pulse_d   <= min_pulse;
      fee_pulse <= 1'b0;
      if (clr) begin
        state    <= IDLE;
        wait_min <= 8'h00;
        bill_cnt <= 4'd0;
        max      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            wait_min <= 8'h00;
            bill_cnt <= 4'd0;
            max      <= 1'b0;
            if (en) begin
              state <= (FREE_MIN == 0) ? BILL : FREE;
            end
          end
          FREE: begin
            if (tick) begin
              wait_min <= wait_inc;
              if (wait_inc == FREE_BCD) begin
                state    <= BILL;
                bill_cnt <= 4'd0;
              end
            end
          end
          BILL: begin
            if (tick) begin
              wait_min <= wait_inc;
              if (bill_inc == STEP) begin
                fee_pulse <= 1'b1;
                bill_cnt  <= 4'd0;
              end else begin
                bill_cnt  <= bill_inc;
              end
              if (wait_inc == MAX_BCD) begin
                state <= SAT;
                max   <= 1'b1;
              end
            end
          end
          SAT: begin
            max <= 1'b1;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wait_time_cnt.sv
// tb_wait_time_cnt
//   Three instances run from the same stimulus:
//     a: defaults (FREE_MIN=3, BILL_STEP=1, MAX_MIN=99)
//     b: BILL_STEP=2
//     c: FREE_MIN=0, MAX_MIN=12
//   A minute-level model predicts every instance on every cycle. A directed
//   vector table and a few hand-written sequences cover the corner cases.
module tb_wait_time_cnt;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic min_pulse = 1'b0;

  logic [7:0] wm_a, wm_b, wm_c;
  logic       fp_a, fp_b, fp_c;
  logic       mx_a, mx_b, mx_c;

  int errors = 0;
  int checks = 0;

  always #10 clk = ~clk;

  wait_time_cnt #(.FREE_MIN(3), .BILL_STEP(1), .MAX_MIN(99)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .min_pulse(min_pulse),
    .wait_min(wm_a), .fee_pulse(fp_a), .max(mx_a));
  wait_time_cnt #(.FREE_MIN(3), .BILL_STEP(2), .MAX_MIN(99)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .min_pulse(min_pulse),
    .wait_min(wm_b), .fee_pulse(fp_b), .max(mx_b));
  wait_time_cnt #(.FREE_MIN(0), .BILL_STEP(1), .MAX_MIN(12)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .min_pulse(min_pulse),
    .wait_min(wm_c), .fee_pulse(fp_c), .max(mx_c));

  // Reference model: an integer minute count plus an "armed" flag, which
  // stands for the one-cycle start-up after en is first seen. A fee falls on
  // every minute n above the free allowance where (n - FREE) is a multiple
  // of STEP.
  localparam int P_FREE [3] = '{3, 3, 0};
  localparam int P_STEP [3] = '{1, 2, 1};
  localparam int P_MAX  [3] = '{99, 99, 12};

  int m_cnt [3] = '{0, 0, 0};
  bit m_arm [3] = '{0, 0, 0};
  bit m_pd  [3] = '{0, 0, 0};
  bit m_fee [3] = '{0, 0, 0};

  always @(posedge clk or negedge rst_n) begin
    bit t;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        m_cnt[k] = 0; m_arm[k] = 0; m_pd[k] = 0; m_fee[k] = 0;
      end else begin
        t        = min_pulse && !m_pd[k] && en;
        m_pd[k]  = min_pulse;
        m_fee[k] = 0;
        if (clr) begin
          m_arm[k] = 0;
          m_cnt[k] = 0;
        end else if (!m_arm[k]) begin
          m_arm[k] = en;
        end else if (t && m_cnt[k] < P_MAX[k]) begin
          m_cnt[k] = m_cnt[k] + 1;
          if (m_cnt[k] > P_FREE[k] && ((m_cnt[k] - P_FREE[k]) % P_STEP[k]) == 0)
            m_fee[k] = 1;
        end
      end
    end
  end

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_one(input int k, input logic [7:0] wm, input logic fp, input logic mx);
    check($sformatf("model%0d wait_min", k), wm, to_bcd(m_cnt[k]));
    check($sformatf("model%0d fee_pulse", k), {7'd0, fp}, {7'd0, m_fee[k]});
    check($sformatf("model%0d max", k), {7'd0, mx}, {7'd0, (m_cnt[k] == P_MAX[k])});
  endtask

  // Compare every instance with the model, then apply the next inputs. Both
  // happen on the falling edge, away from the active edge.
  task automatic drive(input bit e, input bit c, input bit p);
    @(negedge clk);
    cmp_one(0, wm_a, fp_a, mx_a);
    cmp_one(1, wm_b, fp_b, mx_b);
    cmp_one(2, wm_c, fp_c, mx_c);
    en = e; clr = c; min_pulse = p;
  endtask

  typedef struct {
    bit         en;
    bit         clr;
    bit         pls;
    logic [7:0] w;    // expected wait_min of a
    bit         f;    // expected fee_pulse of a
    bit         m;    // expected max of a
    bit         fb;   // expected fee_pulse of b
  } vec_t;

  vec_t tbl [18];

  initial begin
    logic [7:0] held;
    bit         fee_seen;
    int         c;

    tbl[0]  = '{1, 0, 0, 8'h00, 0, 0, 0};  // IDLE -> FREE
    tbl[1]  = '{1, 0, 1, 8'h01, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 8'h01, 0, 0, 0};
    tbl[3]  = '{1, 0, 1, 8'h02, 0, 0, 0};
    tbl[4]  = '{1, 0, 0, 8'h02, 0, 0, 0};
    tbl[5]  = '{1, 0, 1, 8'h03, 0, 0, 0};  // free allowance used up
    tbl[6]  = '{1, 0, 0, 8'h03, 0, 0, 0};
    tbl[7]  = '{1, 0, 1, 8'h04, 1, 0, 0};  // first billed minute
    tbl[8]  = '{1, 0, 0, 8'h04, 0, 0, 0};
    tbl[9]  = '{1, 0, 1, 8'h05, 1, 0, 1};  // wide pulse starts; b bills on 5
    tbl[10] = '{1, 0, 1, 8'h05, 0, 0, 0};
    tbl[11] = '{1, 0, 1, 8'h05, 0, 0, 0};
    tbl[12] = '{1, 0, 0, 8'h05, 0, 0, 0};
    tbl[13] = '{0, 0, 1, 8'h05, 0, 0, 0};  // paused pulse is ignored
    tbl[14] = '{1, 0, 0, 8'h05, 0, 0, 0};
    tbl[15] = '{1, 1, 1, 8'h00, 0, 0, 0};  // clear beats the tick
    tbl[16] = '{1, 0, 0, 8'h00, 0, 0, 0};
    tbl[17] = '{1, 0, 1, 8'h01, 0, 0, 0};

    // Reset state
    repeat (50) @(posedge clk);
    @(negedge clk);
    check("reset wait_min", wm_a, 8'h00);
    check("reset fee_pulse", {7'd0, fp_a}, 8'h00);
    check("reset max", {7'd0, mx_a}, 8'h00);
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].en, tbl[i].clr, tbl[i].pls);
      @(posedge clk); #1;
      check($sformatf("vec%0d wait_min", i), wm_a, tbl[i].w);
      check($sformatf("vec%0d fee_pulse", i), {7'd0, fp_a}, {7'd0, tbl[i].f});
      check($sformatf("vec%0d max", i), {7'd0, mx_a}, {7'd0, tbl[i].m});
      check($sformatf("vec%0d fee_pulse_b", i), {7'd0, fp_b}, {7'd0, tbl[i].fb});
    end

    // Count into BILL, then pause for 30 minute periods
    c = 0;
    while (m_cnt[0] < 6 && c < 200) begin
      drive(1, 0, (c % 10) == 0);
      c++;
    end
    drive(1, 0, 0);
    @(posedge clk); #1;
    held = wm_a;
    fee_seen = 0;
    for (int i = 0; i < 300; i++) begin
      drive(0, 0, (i % 10) == 0);
      fee_seen |= fp_a | fp_b | fp_c;
    end
    check("pause wait_min held", wm_a, held);
    check("pause fee_pulse none", {7'd0, fee_seen}, 8'h00);

    // Resume and run to saturation; later ticks must not move anything
    for (int i = 0; i < 1200; i++) drive(1, 0, (i % 10) == 0);
    drive(1, 0, 0);
    check("sat wait_min a", wm_a, 8'h99);
    check("sat max a", {7'd0, mx_a}, 8'h01);
    check("sat wait_min c", wm_c, 8'h12);
    check("sat max c", {7'd0, mx_c}, 8'h01);

    // Clear in the same cycle as a tick
    drive(1, 1, 1);
    @(posedge clk); #1;
    check("clr+tick wait_min", wm_a, 8'h00);
    check("clr+tick max", {7'd0, mx_a}, 8'h00);

    // Count to 57, then reset asynchronously between clock edges
    c = 0;
    while (m_cnt[0] != 57 && c < 1000) begin
      drive(1, 0, (c % 10) == 1);
      c++;
    end
    check("pre-reset wait_min", wm_a, 8'h57);
    #3 rst_n = 1'b0;
    #1;
    check("async reset wait_min", wm_a, 8'h00);
    check("async reset max c", {7'd0, mx_c}, 8'h00);
    check("async reset wait_min b", wm_b, 8'h00);
    en = 1'b0; clr = 1'b0; min_pulse = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 499) == 0,
            $urandom_range(0, 5) == 0);
    end
    drive(1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
